// File: rtl/blink_pkg.sv
// Shared types and default constants for the LED blink monitor.
package blink_pkg;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int CBITS_DEF  = 14;
  localparam int LOCK_N_DEF = 2;

endpackage : blink_pkg

// File: rtl/blink_edge_det.sv
// Samples the LED level and wrap strobe; reports qualified edges and edges
// that arrive without a preceding wrap strobe.
module blink_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic led_i,
  input  logic flg_i,
  output logic edge_o,
  output logic sync_err_o
);

  logic led_q;
  logic flg_q;
  logic primed_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q    <= 1'b0;
      flg_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      led_q    <= led_i;
      flg_q    <= flg_i;
      primed_q <= 1'b1;
    end
  end

  // led_q is not a real history sample until primed, so the first cycle
  // after reset can never report an edge.
  assign edge_o     = primed_q & (led_i ^ led_q);
  assign sync_err_o = edge_o & ~flg_q;

endmodule : blink_edge_det

// File: rtl/blink_monitor.sv
// Checks that an LED toggles every 2^CBITS clocks in step with its generator's
// wrap strobe; locks after LOCK_N good half-periods and latches faults.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CBITS  = CBITS_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led,
  input  logic             flg,
  input  logic             clr,
  output logic             locked,
  output logic             err_period,
  output logic             err_sync,
  output logic [CBITS:0]   half_period,
  output logic             edge_p
);

  localparam logic [CBITS:0] CNT_ONE  = (CBITS+1)'(1);
  localparam logic [CBITS:0] HALF     = CNT_ONE << CBITS;
  localparam logic [CBITS:0] CNT_MAX  = '1;
  localparam logic [3:0]     GOOD_MAX = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [CBITS:0]   cnt_q, cnt_d;
  logic [3:0]       good_q, good_d, good_inc;
  logic             err_period_q, err_period_d;
  logic             err_sync_q, err_sync_d;
  logic [CBITS:0]   half_period_q, half_period_d;
  logic             locked_q;
  logic             edge_p_q;
  logic             edge_w;
  logic             sync_err_w;

  blink_edge_det u_edge_det (
    .clk        (clk),
    .rst        (rst),
    .led_i      (led),
    .flg_i      (flg),
    .edge_o     (edge_w),
    .sync_err_o (sync_err_w)
  );

  assign good_inc = (good_q < GOOD_MAX) ? good_q + 4'd1 : good_q;

  // NOTE: every _d gets its hold value first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    good_d        = good_q;
    err_period_d  = err_period_q;
    err_sync_d    = err_sync_q;
    half_period_d = half_period_q;

    if (clr) begin
      state_d      = SEEK;
      cnt_d        = '0;
      good_d       = '0;
      err_period_d = 1'b0;
      err_sync_d   = 1'b0;
    end else begin
      unique case (state_q)
        SEEK: begin
          if (edge_w) begin
            state_d = TRACK;
            cnt_d   = CNT_ONE;
            good_d  = '0;
          end
        end
        TRACK, LOCK: begin
          if (edge_w) begin
            half_period_d = cnt_q;
            cnt_d         = CNT_ONE;
            if (sync_err_w) begin
              err_sync_d = 1'b1;
              state_d    = FAULT;
            end else if (cnt_q == HALF) begin
              good_d = good_inc;
              if (good_inc == GOOD_MAX) state_d = LOCK;
            end else begin
              err_period_d = 1'b1;
              state_d      = FAULT;
            end
          end else if (cnt_q == HALF) begin
            // A full half-period elapsed with no edge: report HALF+1.
            err_period_d  = 1'b1;
            half_period_d = HALF + CNT_ONE;
            state_d       = FAULT;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        FAULT: ;
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= SEEK;
      cnt_q         <= '0;
      good_q        <= '0;
      err_period_q  <= 1'b0;
      err_sync_q    <= 1'b0;
      half_period_q <= '0;
      locked_q      <= 1'b0;
      edge_p_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      err_period_q  <= err_period_d;
      err_sync_q    <= err_sync_d;
      half_period_q <= half_period_d;
      locked_q      <= (state_d == LOCK);
      edge_p_q      <= edge_w;
    end
  end

  assign locked      = locked_q;
  assign err_period  = err_period_q;
  assign err_sync    = err_sync_q;
  assign half_period = half_period_q;
  assign edge_p      = edge_p_q;

endmodule : blink_monitor

// File: tb/tb_blink_monitor.sv
// Table-driven bench for blink_monitor (CBITS=4, LOCK_N=2) with a scoreboard
// queue of expected post-edge outputs plus hand-written corner sequences.
module tb_blink_monitor;

  localparam int CBITS  = 4;
  localparam int LOCK_N = 2;

  typedef struct {
    int gap;
    bit flg_ok;
    bit locked;
    bit err_period;
    bit err_sync;
    int half;
  } vec_t;

  typedef struct {
    bit locked;
    bit err_period;
    bit err_sync;
    int half;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           led = 1'b0;
  logic           flg = 1'b0;
  logic           clr = 1'b0;
  logic           locked;
  logic           err_period;
  logic           err_sync;
  logic [CBITS:0] half_period;
  logic           edge_p;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  blink_monitor #(.CBITS(CBITS), .LOCK_N(LOCK_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .led         (led),
    .flg         (flg),
    .clr         (clr),
    .locked      (locked),
    .err_period  (err_period),
    .err_sync    (err_sync),
    .half_period (half_period),
    .edge_p      (edge_p)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int gap, bit f, bit l, bit ep, bit es, int h);
    vec_t v;
    v.gap = gap; v.flg_ok = f; v.locked = l;
    v.err_period = ep; v.err_sync = es; v.half = h;
    return v;
  endfunction

  // Toggle led 'gap' cycles after the previous toggle interval, with flg
  // raised in the cycle just before the toggle when with_flg is set.
  task automatic toggle_after(int gap, bit with_flg);
    for (int i = 1; i < gap; i++) begin
      flg = (i == gap - 1) && with_flg;
      tick();
    end
    flg = 1'b0;
    led = ~led;
    tick();
  endtask

  task automatic apply_range(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t e;
      e.locked = tbl[i].locked; e.err_period = tbl[i].err_period;
      e.err_sync = tbl[i].err_sync; e.half = tbl[i].half;
      exp_q.push_back(e);
      toggle_after(tbl[i].gap, tbl[i].flg_ok);
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d_scoreboard_empty", i), 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_edge_p", i), edge_p, 1);
        check($sformatf("v%0d_locked", i), locked, e.locked);
        check($sformatf("v%0d_err_period", i), err_period, e.err_period);
        check($sformatf("v%0d_err_sync", i), err_sync, e.err_sync);
        check($sformatf("v%0d_half_period", i), half_period, e.half);
      end
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // 0..19: ideal generator; lock after the third edge.
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk((i == 0) ? 5 : 16, 1, i >= 2, 0, 0, (i == 0) ? 0 : 16));
    tbl.push_back(mk(15, 1, 0, 1, 0, 15));   // 20: short period while locked
    tbl.push_back(mk(5,  1, 0, 0, 0, 15));   // 21..23: relock after clr
    tbl.push_back(mk(16, 1, 0, 0, 0, 16));
    tbl.push_back(mk(16, 1, 1, 0, 0, 16));
    tbl.push_back(mk(5,  1, 0, 0, 0, 17));   // 24: reacquire after timeout
    tbl.push_back(mk(16, 0, 0, 0, 1, 16));   // 25: edge without flg
    tbl.push_back(mk(9,  1, 0, 0, 1, 16));   // 26: ignored in FAULT
    tbl.push_back(mk(7,  1, 0, 0, 0, 16));   // 27: SEEK after clr+edge
    tbl.push_back(mk(7,  1, 0, 0, 0, 0));    // 28..29: after reset, led=1
    tbl.push_back(mk(16, 1, 0, 0, 0, 16));
    tbl.push_back(mk(5,  1, 0, 0, 0, 0));    // 30..32: after mid-TRACK reset
    tbl.push_back(mk(16, 1, 0, 0, 0, 16));
    tbl.push_back(mk(16, 1, 1, 0, 0, 16));

    rst = 1'b0;
    tick();
    tick();
    check("rst_locked", locked, 0);
    check("rst_err_period", err_period, 0);
    check("rst_err_sync", err_sync, 0);
    check("rst_half_period", half_period, 0);
    check("rst_edge_p", edge_p, 0);
    rst = 1'b1;
    tick();

    apply_range(0, 20);

    do_clr();
    check("clr_err_period", err_period, 0);
    check("clr_err_sync", err_sync, 0);
    check("clr_locked", locked, 0);
    check("clr_half_kept", half_period, 15);

    apply_range(21, 23);

    // Hold led after lock: timeout one cycle after cnt reaches HALF.
    repeat (15) tick();
    check("to_pre_locked", locked, 1);
    check("to_pre_err", err_period, 0);
    tick();
    check("to_locked", locked, 0);
    check("to_err_period", err_period, 1);
    check("to_half_period", half_period, 17);

    do_clr();
    apply_range(24, 26);

    // clr and an edge in the same cycle: clr wins, block stays in SEEK.
    clr = 1'b1;
    led = ~led;
    tick();
    clr = 1'b0;
    check("clr_edge_err_sync", err_sync, 0);
    check("clr_edge_locked", locked, 0);
    apply_range(27, 27);

    // Reset released with led high: no edge pulse, block stays in SEEK.
    rst = 1'b0;
    led = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rel_edge_p_1", edge_p, 0);
    tick();
    check("rel_edge_p_2", edge_p, 0);
    check("rel_half_period", half_period, 0);
    apply_range(28, 29);

    // One-cycle reset mid-TRACK clears every output.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err_period", err_period, 0);
    check("mid_rst_err_sync", err_sync, 0);
    check("mid_rst_half_period", half_period, 0);
    check("mid_rst_edge_p", edge_p, 0);
    apply_range(30, 32);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_blink_monitor

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 CBITS, 14, log2 of the expected LED half-period in clocks; HALF = 2^CBITS.
REQ-002 LOCK_N, 2, consecutive correct half-periods required to declare lock (range 1..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 led  input  1  monitored blink level, synchronous to clk.
REQ-006 flg  input  1  one-cycle wrap strobe from the blink generator.
REQ-007 clr  input  1  clears FAULT and restarts acquisition.
REQ-008 locked  output  1  high while in LOCK.
REQ-009 err_period  output  1  sticky; set when a half-period is wrong or times out.
REQ-010 err_sync  output  1  sticky; set when an led edge has no flg in the previous cycle.
REQ-011 half_period  output  CBITS+1  cycles between the last two led edges, or the timeout value.
REQ-012 edge_p  output  1  one-cycle pulse on each detected led edge.

Function
REQ-013 Register led into led_q every cycle; edge = led xor led_q, qualified by the primed flag.
REQ-014 The primed flag is 0 after reset and 1 from the second cycle on, so the first sample after reset is never an edge.
REQ-015 Register flg into flg_q; an edge with flg_q = 0 sets err_sync and moves to FAULT; edges are checked only in TRACK and LOCK.
REQ-016 The states are SEEK, TRACK, LOCK and FAULT.
REQ-017 SEEK: wait for an edge; on edge, go to TRACK with cnt = 1 and good = 0.
REQ-018 TRACK and LOCK: cnt increments each cycle and saturates at 2^(CBITS+1)-1.
REQ-019 On an edge in TRACK or LOCK: half_period <= cnt and cnt <= 1.
REQ-020 If that cnt = HALF, good increments, saturating at LOCK_N; when good reaches LOCK_N, go to LOCK.
REQ-021 If that cnt != HALF, set err_period and go to FAULT.
REQ-022 Timeout: in TRACK or LOCK with cnt = HALF and no edge, go to FAULT next cycle with err_period set and half_period = HALF+1.
REQ-023 FAULT: all edges ignored and cnt frozen; stay until clr = 1.
REQ-024 clr = 1 in any state: go to SEEK and clear err_period, err_sync, good and locked next cycle; half_period is retained.
REQ-025 Same-cycle edge and timeout: the edge wins, because the edge is evaluated at cnt = HALF (a good period).
REQ-026 Same-cycle edge and clr: clr wins.
REQ-027 locked is registered and equals (state == LOCK); it drops on the cycle FAULT is entered.
REQ-028 edge_p is registered, 1-cycle latency from the led transition as sampled on led.
REQ-029 The fault checks of REQ-015, REQ-021 and REQ-022 are evaluated in TRACK and in LOCK.

Reset
REQ-030 While rst = 0 at a clock edge, the block SHALL load: state = SEEK, cnt = 0, good = 0, led_q = 0, flg_q = 0, primed = 0.
REQ-031 The same reset SHALL drive outputs to: locked = 0, err_period = 0, err_sync = 0, half_period = 0, edge_p = 0.
REQ-032 Reset asserted mid-operation SHALL take effect on the same clock edge and take priority over clr and edge.

Structure
REQ-033 A shared package blink_pkg SHALL hold the state enum type (SEEK, TRACK, LOCK, FAULT) and the default constants CBITS_DEF = 14 and LOCK_N_DEF = 2.
REQ-034 One sub-module, blink_edge_det, SHALL contain led_q, primed, flg_q and the edge qualification; the FSM and counter stay in blink_monitor.

Verification
(All with CBITS = 4, HALF = 16, LOCK_N = 2, unless noted.)
REQ-035 Ideal generator (led toggles every 16 cycles, flg one cycle before each toggle) -> locked = 1 the cycle after the 3rd edge, half_period = 16, no errors over 20 edges.
REQ-036 One half-period shortened to 15 cycles while locked -> half_period = 15, err_period = 1, locked = 0 the next cycle; then clr -> SEEK with errors cleared, and the block relocks after 3 edges.
REQ-037 led held constant after lock -> FAULT when cnt reaches 16 without an edge, err_period = 1, half_period = 17.
REQ-038 led toggled with flg held 0 in TRACK -> err_sync = 1, state FAULT, err_period = 0.
REQ-039 led = 1 at reset release -> no edge_p pulse and state stays SEEK.
REQ-040 rst low for one cycle mid-TRACK -> all outputs 0 on the next cycle, and acquisition restarts.
